multi_cycle_controller: RTL

//  Main FSM sequencing the multi-cycle RV32I datapath (lw, sw, add/sub/and/or/slt, addi/andi/ori/slti, beq, jal).

---
 rtl/multi_cycle_controller.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_controller.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences fetch, decode and execute,
// drives datapath enables and mux selects, and traps on illegal encodings or memory timeout.
module multi_cycle_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_srst_n,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  input  logic       i_zeroFlag,
  input  logic       i_memReady,
  output logic       o_pcWrite,
  output logic       o_addressSrc,
  output logic       o_instructionRegWrite,
  output logic       o_memWriteEn,
  output logic       o_regWriteEn,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [3:0] o_aluLogicOperation,
  output logic [1:0] o_resultSel,
  output logic       o_instrRetired,
  output logic       o_trap,
  output logic [1:0] o_trapCause
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SLT = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // The counter only ever needs to reach MEM_TIMEOUT-1: the next low cycle traps instead.
  localparam int COUNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [COUNT_W-1:0] LAST_WAIT = (MEM_TIMEOUT > 0) ? COUNT_W'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } StateType;

  StateType state, nextState;
  logic [COUNT_W-1:0] waitCount;
  logic [1:0] trapCause, nextCause;
  logic memWait, timedOut, aluFunct3Ok;
  logic pcWriteRaw, irWriteRaw, memWriteRaw, regWriteRaw, retiredRaw;

  function automatic logic [3:0] aluOpFor(input logic [2:0] funct3, input logic isSub);
    case (funct3)
      3'b000:  return isSub ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  assign memWait     = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign aluFunct3Ok = i_funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
  assign timedOut    = (MEM_TIMEOUT > 0) && memWait && !i_memReady && (waitCount == LAST_WAIT);

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      state     <= FETCH;
      waitCount <= '0;
      trapCause <= CAUSE_NONE;
    end else begin
      state     <= nextState;
      trapCause <= nextCause;
      if (memWait && (nextState == state)) waitCount <= waitCount + COUNT_W'(1);
      else                                 waitCount <= '0;
    end
  end

  always_comb begin
    nextState           = state;
    nextCause           = trapCause;
    pcWriteRaw          = 1'b0;
    irWriteRaw          = 1'b0;
    memWriteRaw         = 1'b0;
    regWriteRaw         = 1'b0;
    retiredRaw          = 1'b0;
    o_addressSrc        = 1'b0;
    o_aluSrcA           = 2'b00;
    o_aluSrcB           = 2'b00;
    o_aluLogicOperation = ALU_ADD;
    o_resultSel         = 2'b00;
    case (state)
      FETCH: begin
        o_aluSrcB   = 2'b10;
        o_resultSel = 2'b10;
        if (i_memReady) begin
          pcWriteRaw = 1'b1;
          irWriteRaw = 1'b1;
          nextState  = DECODE;
        end else if (timedOut) begin
          nextState = TRAP;
          nextCause = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        o_aluSrcA = 2'b01;
        o_aluSrcB = 2'b01;
        nextState = TRAP;
        case (i_opcode)
          OP_LOAD, OP_STORE: if (i_funct3 == 3'b010) nextState = MEMADR;
          OP_REG:            if (aluFunct3Ok) nextState = EXECR;
          OP_IMM:            if (aluFunct3Ok) nextState = EXECI;
          OP_BRANCH:         if (i_funct3 == 3'b000) nextState = BEQ;
          OP_JAL:            nextState = JAL;
          default:           nextState = TRAP;
        endcase
        if (nextState == TRAP) nextCause = CAUSE_ILLEGAL;
      end
      MEMADR: begin
        o_aluSrcA = 2'b10;
        o_aluSrcB = 2'b01;
        nextState = i_opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        o_addressSrc = 1'b1;
        if (i_memReady) nextState = MEMWB;
        else if (timedOut) begin
          nextState = TRAP;
          nextCause = CAUSE_TIMEOUT;
        end
      end
      MEMWB: begin
        o_resultSel = 2'b01;
        regWriteRaw = 1'b1;
        retiredRaw  = 1'b1;
        nextState   = FETCH;
      end
      MEMWRITE: begin
        o_addressSrc = 1'b1;
        memWriteRaw  = 1'b1;
        if (i_memReady) begin
          retiredRaw = 1'b1;
          nextState  = FETCH;
        end else if (timedOut) begin
          nextState = TRAP;
          nextCause = CAUSE_TIMEOUT;
        end
      end
      EXECR: begin
        o_aluSrcA           = 2'b10;
        o_aluLogicOperation = aluOpFor(i_funct3, i_funct7bit5);
        nextState           = ALUWB;
      end
      EXECI: begin
        o_aluSrcA           = 2'b10;
        o_aluSrcB           = 2'b01;
        o_aluLogicOperation = aluOpFor(i_funct3, 1'b0);
        nextState           = ALUWB;
      end
      ALUWB: begin
        regWriteRaw = 1'b1;
        retiredRaw  = 1'b1;
        nextState   = FETCH;
      end
      BEQ: begin
        o_aluSrcA           = 2'b10;
        o_aluLogicOperation = ALU_SUB;
        pcWriteRaw          = i_zeroFlag;
        retiredRaw          = 1'b1;
        nextState           = FETCH;
      end
      JAL: begin
        o_aluSrcA  = 2'b01;
        o_aluSrcB  = 2'b10;
        pcWriteRaw = 1'b1;
        nextState  = ALUWB;
      end
      TRAP: nextState = TRAP;
      default: nextState = FETCH;
    endcase
  end

  // Reset must suppress any write in the cycle it is asserted, whatever state we are in.
  assign o_pcWrite             = pcWriteRaw & i_srst_n;
  assign o_instructionRegWrite = irWriteRaw & i_srst_n;
  assign o_memWriteEn          = memWriteRaw & i_srst_n;
  assign o_regWriteEn          = regWriteRaw & i_srst_n;
  assign o_instrRetired        = retiredRaw & i_srst_n;
  assign o_trap                = (state == TRAP);
  assign o_trapCause           = trapCause;

endmodule
